sr_bank_scheduler: RTL

- Sequences set and clear pulses into a bank of N discrete SR latches.
- Arbitrates between two requesters (A and B).
- Guarantees the forbidden S=R=1 condition never reaches any latch.
- Enforces a minimum pulse width and a recovery gap between pulses.
- On reset release, initialises every latch to Q=0 before accepting requests.

---
 rtl/sr_sched_pkg.sv | 6 +
 rtl/rr_arb2.sv | 14 +
 rtl/sr_bank_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/sr_sched_pkg.sv
// sr_sched_pkg: shared opcode/state types for the SR latch bank scheduler
package sr_sched_pkg;
  localparam int OPW = 2;
  typedef enum logic [OPW-1:0] {OP_SET = 2'b00, OP_CLR = 2'b01, OP_TOG = 2'b10, OP_CLR_ALL = 2'b11} op_t;
  typedef enum logic [2:0] {ST_INIT, ST_INIT_GAP, ST_IDLE, ST_ASSERT, ST_RECOVER} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer moves to the loser on each grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt,
  output logic       o_ptr
);
  logic r_ptr;
  assign o_gnt = {i_req[1] & (~i_req[0] | r_ptr), i_req[0] & (~i_req[1] | ~r_ptr)};
  assign o_ptr = r_ptr;
  always_ff @(posedge clk) r_ptr <= !rst_n ? 1'b0 : i_adv ? o_gnt[0] : r_ptr;
endmodule

// File: rtl/sr_bank_scheduler.sv
// sr_bank_scheduler: sequences arbitrated set/clear pulses into a bank of SR latches,
// never driving S and R together and always separating pulses by a recovery gap
module sr_bank_scheduler import sr_sched_pkg::*; #(
  parameter int N         = 8,
  parameter int IDXW      = $clog2(N),
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic [OPW-1:0]  a_op,
  input  logic [IDXW-1:0] a_idx,
  output logic            a_ack,
  input  logic            b_req,
  input  logic [OPW-1:0]  b_op,
  input  logic [IDXW-1:0] b_idx,
  output logic            b_ack,
  input  logic [N-1:0]    q_in,
  output logic [N-1:0]    s_out,
  output logic [N-1:0]    r_out,
  output logic            busy,
  output logic            init_done
);
  localparam int CW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);
  state_t          r_st, w_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_started, r_init_done, r_side, r_q;
  op_t             r_op;
  logic [IDXW-1:0] r_idx, w_idx;
  logic [N-1:0]    w_bit, w_new_bit, w_s, w_r;
  logic [1:0]      w_req, w_gnt;
  logic            w_ptr, w_adv, w_side, w_ack;
  assign w_req     = {b_req, a_req};
  assign w_adv     = (r_st == ST_IDLE) && |w_gnt;
  assign w_side    = &w_req ? w_ptr : w_gnt[1];
  assign w_idx     = w_side ? b_idx : a_idx;
  assign w_new_bit = N'(1) << w_idx;
  assign w_bit     = N'(1) << r_idx;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .i_req(w_req), .i_adv(w_adv), .o_gnt(w_gnt), .o_ptr(w_ptr));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st        <= ST_INIT;
      r_cnt       <= '0;
      r_started   <= 1'b0;
      r_init_done <= 1'b0;
      r_side      <= 1'b0;
      r_q         <= 1'b0;
      r_op        <= OP_SET;
      r_idx       <= '0;
    end else begin
      r_st      <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_started <= 1'b1;
      if (r_st == ST_INIT_GAP && w_nxt == ST_IDLE) r_init_done <= 1'b1;
      if (w_adv) begin
        r_side <= w_side;
        r_op   <= op_t'(w_side ? b_op : a_op);
        r_idx  <= w_idx;
        r_q    <= |(q_in & w_new_bit);
      end
    end
  end
  // r_started keeps the bank quiet for the cycle right after a reset edge
  always_comb begin
    w_nxt     = r_st;
    w_cnt_nxt = '0;
    w_s       = '0;
    w_r       = '0;
    w_ack     = 1'b0;
    case (r_st)
      ST_INIT: begin
        w_r       = r_started ? '1 : '0;
        w_cnt_nxt = r_cnt + CW'(r_started);
        if (r_started && r_cnt == CW'(PULSE_CYC - 1)) begin
          w_nxt     = ST_INIT_GAP;
          w_cnt_nxt = '0;
        end
      end
      ST_INIT_GAP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_nxt     = ST_IDLE;
          w_cnt_nxt = '0;
        end
      end
      ST_IDLE: w_nxt = !w_adv ? ST_IDLE : |w_new_bit ? ST_ASSERT : ST_RECOVER;
      ST_ASSERT: begin
        w_s       = (r_op == OP_SET || (r_op == OP_TOG && !r_q)) ? w_bit : '0;
        w_r       = r_op == OP_CLR_ALL ? '1 : (r_op == OP_CLR || (r_op == OP_TOG && r_q)) ? w_bit : '0;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(PULSE_CYC - 1)) begin
          w_nxt     = ST_RECOVER;
          w_cnt_nxt = '0;
        end
      end
      ST_RECOVER: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_ack     = 1'b1;
          w_nxt     = ST_IDLE;
          w_cnt_nxt = '0;
        end
      end
      default: w_nxt = ST_INIT;
    endcase
  end
  assign s_out     = w_s;
  assign r_out     = w_r;
  assign a_ack     = w_ack & ~r_side;
  assign b_ack     = w_ack & r_side;
  assign busy      = r_st != ST_IDLE;
  assign init_done = r_init_done;
endmodule
